// File: rtl/slave_port.sv
// Serial-bus target endpoint: deserialises address/write data, issues one
// parallel memory request, and serialises read data back LSB first.
// Ports: clk, rstn; serial side swdata/smode/mvalid in, srdata/svalid/sready
// out; memory side mem_addr/mem_wdata/mem_wen/mem_valid out with mem_ready,
// and mem_rdata/mem_rvalid in.
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int MAXW =
    (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MAXW + 1);

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_END  = CW'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wbuf;
  logic [DATA_WIDTH-1:0] rbuf;

  // Bits arrive LSB first, so shifting in at the top leaves the
  // word correctly aligned once the final bit lands.
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] wbuf_sh;

  assign addr_sh = {swdata, addr[ADDR_WIDTH-1:1]};
  assign wbuf_sh = {swdata, wbuf[DATA_WIDTH-1:1]};

  // Gated by rstn so every output reads 0 while reset is held.
  assign sready = rstn & (state == S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      addr      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      srdata    <= 1'b0;
      svalid    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mvalid) begin
            addr  <= addr_sh;
            mode  <= smode;
            cnt   <= ONE;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (mvalid) begin
            addr <= addr_sh;
            if (cnt == A_LAST) begin
              cnt <= '0;
              if (mode) begin
                state <= S_WDATA;
              end else begin
                state     <= S_REQ;
                mem_valid <= 1'b1;
                mem_wen   <= 1'b0;
                mem_addr  <= addr_sh;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_WDATA: begin
          if (mvalid) begin
            wbuf <= wbuf_sh;
            if (cnt == D_LAST) begin
              cnt       <= '0;
              state     <= S_REQ;
              mem_valid <= 1'b1;
              mem_wen   <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= wbuf_sh;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= mode ? S_IDLE : S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (mem_rvalid) begin
            rbuf   <= mem_rdata >> 1;
            srdata <= mem_rdata[0];
            svalid <= 1'b1;
            cnt    <= ONE;
            state  <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (cnt == D_END) begin
            svalid <= 1'b0;
            srdata <= 1'b0;
            cnt    <= '0;
            state  <= S_IDLE;
          end else begin
            srdata <= rbuf[0];
            rbuf   <= rbuf >> 1;
            cnt    <= cnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: table of serial transactions plus
// hand-written reset sequences.
module tb_slave_port;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        swdata = 1'b0;
  logic        smode = 1'b0;
  logic        mvalid = 1'b0;
  logic        srdata;
  logic        svalid;
  logic        sready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_rvalid = 1'b0;

  int ncmp = 0;
  int nbad = 0;

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          gap;
    int          rdly;
    int          rvgap;
    logic        stray;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_bits;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] v, input int n,
                           input logic m, input int gmax,
                           input bit first, input bit fin,
                           output bit early);
    int g;
    early = 0;
    for (int i = 0; i < n; i++) begin
      g = 0;
      if (gmax > 0 && $urandom_range(0, 1) == 1)
        g = int'($urandom_range(1, gmax));
      for (int k = 0; k < g; k++) begin
        mvalid = 1'b0;
        tick();
        if (mem_valid) early = 1;
      end
      mvalid = 1'b1;
      swdata = v[i];
      smode  = (first && i == 0) ? m : ~m;
      tick();
      mvalid = 1'b0;
      swdata = 1'b0;
      if (!(fin && i == n - 1) && mem_valid) early = 1;
    end
  endtask

  task automatic do_txn(input vec_t v);
    bit e1, e2, bad;
    logic [7:0] bits;
    e2 = 0;
    mem_ready = (v.rdly == 0);
    send_word({20'd0, v.addr}, 12, v.mode, v.gap, 1, !v.mode, e1);
    if (v.mode)
      send_word({24'd0, v.wdata}, 8, v.mode, v.gap, 0, 1, e2);
    chk("early_mvalid", {62'd0, e1, e2}, 0);
    chk("mvalid_rise", mem_valid, 1);
    chk("req_addr", mem_addr, v.exp_addr);
    chk("req_wen", mem_wen, v.mode);
    if (v.mode) chk("req_wdata", mem_wdata, v.exp_wdata);
    bad = 0;
    for (int k = 0; k < v.rdly; k++) begin
      if (v.stray) begin
        mvalid = k[0];
        swdata = 1'b1;
        smode  = ~v.mode;
      end
      tick();
      mvalid = 1'b0;
      if (!mem_valid || mem_addr !== v.exp_addr
          || mem_wen !== v.mode
          || (v.mode && mem_wdata !== v.exp_wdata))
        bad = 1;
    end
    if (v.rdly > 0) chk("req_hold", bad, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("hs_drop", mem_valid, 0);
    if (v.mode) begin
      chk("w_sready", sready, 1);
    end else begin
      chk("rwait_busy", sready, 0);
      for (int k = 0; k < v.rvgap; k++) tick();
      mem_rdata  = v.rdata;
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
      bad = 0;
      bits = 8'h00;
      for (int i = 0; i < 8; i++) begin
        bits[i] = srdata;
        if (!svalid) bad = 1;
        tick();
      end
      chk("rd_bits", bits, v.exp_bits);
      chk("svalid_run", bad, 0);
      chk("svalid_end", svalid, 0);
      chk("r_sready", sready, 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    vecs[0] = '{1'b1, 12'h0A5, 8'h3C, 8'h00, 0, 0, 0, 1'b0,
                12'h0A5, 8'h3C, 8'h00};
    vecs[1] = '{1'b0, 12'hFFF, 8'h00, 8'hA5, 0, 3, 1, 1'b0,
                12'hFFF, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 12'h0A5, 8'h3C, 8'h00, 3, 0, 0, 1'b0,
                12'h0A5, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 12'h123, 8'h77, 8'h00, 0, 5, 0, 1'b1,
                12'h123, 8'h77, 8'h00};
    vecs[4] = '{1'b0, 12'h010, 8'h00, 8'h5A, 0, 0, 0, 1'b0,
                12'h010, 8'h00, 8'h5A};
    vecs[5] = '{1'b1, 12'h3C3, 8'h81, 8'h00, 0, 0, 0, 1'b0,
                12'h3C3, 8'h81, 8'h00};
    vecs[6] = '{1'b0, 12'h800, 8'h00, 8'h80, 2, 1, 0, 1'b1,
                12'h800, 8'h00, 8'h80};

    #3;
    chk("rst_outs",
        {mem_valid, svalid, srdata, sready, mem_wen,
         mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("idle_sready", sready, 1);

    foreach (vecs[i]) do_txn(vecs[i]);

    // Reset after four write-data bits.
    mem_ready = 1'b0;
    send_word(32'h555, 12, 1'b1, 0, 1, 0, e);
    send_word(32'hF0, 4, 1'b1, 0, 0, 0, e);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_outs",
        {mem_valid, svalid, srdata, sready, mem_wen,
         mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    do_txn('{1'b1, 12'h001, 8'hFF, 8'h00, 0, 0, 0, 1'b0,
             12'h001, 8'hFF, 8'h00});

    // Reset while a read request is pending.
    mem_ready = 1'b0;
    send_word(32'h7FF, 12, 1'b0, 0, 1, 1, e);
    chk("pend_mvalid", mem_valid, 1);
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mvalid_drop", mem_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_rst_sready", sready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
